// File: rtl/itoa_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | itoa_seq                                                                 |
// | Converts a 32-bit integer to a decimal ASCII byte stream, MSD first.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module itoa_seq #(
  parameter int APPEND_NL = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_conv = 2'd1;
  localparam logic [1:0] c_emit = 2'd2;
  localparam logic [3:0] c_nl   = (APPEND_NL != 0) ? 4'd1 : 4'd0;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;

  logic [31:0] r_mag;
  logic        r_neg;
  logic [3:0]  r_cnt;
  logic [7:0]  r_buf [0:9];
  logic [3:0]  r_pos;
  logic        r_out_valid;
  logic [7:0]  r_out_data;
  logic        r_out_last;

  logic        w_neg_in;
  logic [31:0] w_mag_in;
  logic [31:0] w_q;
  logic [31:0] w_mul10;
  logic [7:0]  w_digit;
  logic [3:0]  w_total;
  logic        w_more;
  logic        w_is_last;
  logic [3:0]  w_didx;
  logic [3:0]  w_bidx;
  logic [7:0]  w_byte;
  logic        w_accept;
  logic        w_take;
  logic        w_load;

  // Request-side magnitude; 0x80000000 negates to itself, which is the right unsigned value.
  assign w_neg_in = in_signed & in_data[31];
  assign w_mag_in = w_neg_in ? (32'd0 - in_data) : in_data;

  // Reciprocal-multiply divide by ten, then remainder via shift-add times ten.
  assign w_q     = 32'(({32'd0, r_mag} * 64'hCCCC_CCCD) >> 35);
  assign w_mul10 = (w_q << 3) + (w_q << 1);
  assign w_digit = 8'h30 + 8'(r_mag - w_mul10);

  assign w_total   = {3'b000, r_neg} + r_cnt + c_nl;
  assign w_more    = (r_pos < w_total);
  assign w_is_last = (r_pos == (w_total - 4'd1));

  // Stream position r_pos maps to sign, then digits newest-first, then newline.
  always_comb begin
    w_didx = r_pos - {3'b000, r_neg};
    w_bidx = r_cnt - 4'd1 - w_didx;
    w_byte = 8'h0A;
    if (r_neg && (r_pos == 4'd0)) begin
      w_byte = 8'h2D;
    end else if (w_didx < r_cnt) begin
      w_byte = r_buf[w_bidx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: if (in_valid)               w_state_nxt = c_conv;
      c_conv: if (w_q == 32'd0)           w_state_nxt = c_emit;
      c_emit: if (w_take && r_out_last)   w_state_nxt = c_idle;
      default:                            w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    in_ready = (r_state == c_idle);
    busy     = (r_state != c_idle);
    w_accept = (r_state == c_idle) && in_valid;
    w_take   = r_out_valid && out_ready;
    w_load   = (r_state == c_emit) && w_more && (!r_out_valid || out_ready);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mag       <= 32'd0;
      r_neg       <= 1'b0;
      r_cnt       <= 4'd0;
      r_pos       <= 4'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
      for (int i = 0; i < 10; i++) begin
        r_buf[i] <= 8'h00;
      end
    end else begin
      if (w_accept) begin
        r_mag <= w_mag_in;
        r_neg <= w_neg_in;
        r_cnt <= 4'd0;
        r_pos <= 4'd0;
      end
      if (r_state == c_conv) begin
        r_buf[r_cnt] <= w_digit;
        r_cnt        <= r_cnt + 4'd1;
        r_mag        <= w_q;
      end
      // Load the next byte whenever the output register is empty or being drained.
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_byte;
        r_out_last  <= w_is_last;
        r_pos       <= r_pos + 4'd1;
      end else if (w_take) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_itoa_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_itoa_seq                                                              |
// | Directed and random conversions against a decimal-string reference.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_itoa_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_signed = 1'b0;
  logic        out_ready = 1'b0;
  logic        sel = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic        ir0, ov0, ol0, b0, ir1, ov1, ol1, b1;
  logic [7:0]  od0, od1;
  logic        in_ready, out_valid, out_last, busy;
  logic [7:0]  out_data;
  logic        iv0, iv1;

  logic [7:0]  exp_q [$];
  int          g_ndig;
  bit          g_neg;

  assign iv0       = in_valid & ~sel;
  assign iv1       = in_valid & sel;
  assign in_ready  = sel ? ir1 : ir0;
  assign out_valid = sel ? ov1 : ov0;
  assign out_data  = sel ? od1 : od0;
  assign out_last  = sel ? ol1 : ol0;
  assign busy      = sel ? b1 : b0;

  itoa_seq #(.APPEND_NL(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .in_valid(iv0), .in_ready(ir0), .in_data(in_data),
    .in_signed(in_signed), .out_valid(ov0), .out_ready(out_ready & ~sel),
    .out_data(od0), .out_last(ol0), .busy(b0)
  );

  itoa_seq #(.APPEND_NL(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .in_valid(iv1), .in_ready(ir1), .in_data(in_data),
    .in_signed(in_signed), .out_valid(ov1), .out_ready(out_ready & sel),
    .out_data(od1), .out_last(ol1), .busy(b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected stream straight from the decimal rendering of the value.
  function automatic void model(input logic [31:0] d, input logic s, input bit nl);
    longint v;
    string  str;
    if (s) v = longint'($signed(d));
    else   v = longint'({32'd0, d});
    exp_q.delete();
    g_neg = (v < 0);
    if (g_neg) begin
      v = -v;
      exp_q.push_back(8'h2D);
    end
    str    = $sformatf("%0d", v);
    g_ndig = str.len();
    for (int i = 0; i < str.len(); i++) exp_q.push_back(str[i]);
    if (nl) exp_q.push_back(8'h0A);
  endfunction

  task automatic run(input logic [31:0] d, input logic s, input bit rnd, input bit nl);
    int t0, first_v, busy_low, idx, n_bytes;
    bit done, hold;
    logic [7:0] pd;
    logic pl;
    model(d, s, nl);
    n_bytes = exp_q.size();
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_data   = d;
    in_signed = s;
    @(negedge clk);
    t0        = cyc;
    in_valid  = 1'b0;
    in_data   = $urandom;
    first_v   = -1;
    busy_low  = -1;
    idx       = 0;
    done      = 1'b0;
    hold      = 1'b0;
    pd        = 8'h00;
    pl        = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
        chk("hold_last", out_last, pl);
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (!busy) begin
        done     = 1'b1;
        busy_low = cyc;
      end else begin
        chk("busy_in_ready", in_ready, 0);
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_valid && out_ready) begin
          if (idx < n_bytes) begin
            chk("byte", out_data, exp_q[idx]);
            chk("last", out_last, (idx == n_bytes - 1));
          end else begin
            chk("extra_byte", idx, n_bytes);
          end
          idx++;
        end
        hold = out_valid && !out_ready;
        pd   = out_data;
        pl   = out_last;
        @(negedge clk);
      end
    end
    out_ready = 1'b0;
    chk("timeout", done, 1);
    chk("byte_count", idx, n_bytes);
    chk("end_valid", out_valid, 0);
    chk("end_in_ready", in_ready, 1);
    if (!rnd) begin
      chk("first_valid_lat", first_v - t0, g_ndig + 1);
      chk("busy_low_lat", busy_low - t0, g_ndig + 1 + n_bytes);
    end
  endtask

  initial begin
    logic [31:0] d;
    int acc;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
    end
    sel  = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    run(32'd0, 1'b0, 1'b0, 1'b0);
    run(32'd1234567890, 1'b0, 1'b0, 1'b0);
    run(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run(32'h8000_0000, 1'b1, 1'b0, 1'b0);
    sel = 1'b1;
    run(32'h8000_0000, 1'b1, 1'b0, 1'b1);
    run(32'd0, 1'b0, 1'b0, 1'b1);
    sel = 1'b0;
    run(32'd907, 1'b0, 1'b1, 1'b0);
    run(32'd907, 1'b0, 1'b1, 1'b0);

    // Abandon "123456" after two accepted bytes.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 32'd123456;
    in_signed = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    acc      = 0;
    for (int k = 0; k < 100 && acc < 2; k++) begin
      if (out_valid && out_ready) begin
        chk("rst_pre_byte", out_data, (acc == 0) ? 32'h31 : 32'h32);
        acc++;
      end
      @(negedge clk);
    end
    chk("rst_pre_count", acc, 2);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    chk("midrst_quiet", out_valid, 0);
    out_ready = 1'b0;
    run(32'd42, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      d = $urandom;
      if (k % 3 == 0) d = 32'($urandom_range(0, 999));
      run(d, 1'($urandom_range(0, 1)), k[0], 1'b0);
    end
    sel = 1'b1;
    for (int k = 0; k < 6; k++) begin
      d = $urandom;
      run(d, 1'($urandom_range(0, 1)), k[0], 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/itoa_seq.md
Name: itoa_seq

Overview:
- Sequencer that drives the mul10/div10 helper datapath to convert a 32-bit integer into a decimal ASCII byte stream, most significant digit first.
- Sits between the core's integer-print path and the UART transmit byte FIFO.
- Accepts one word via valid/ready and emits one byte per accepted out_ready beat.
- Supports unsigned or two's-complement signed input, selected per request.

Parameters:
APPEND_NL, 0, when 1 append byte 0x0A after the last digit; out_last then marks the 0x0A.

Ports:
clk  in  1  clock; all state updates on rising edge
rstn  in  1  reset, synchronous, active-low
in_valid  in  1  request present
in_ready  out  1  block can accept a request
in_data  in  32  value to convert
in_signed  in  1  1: treat in_data as two's complement; 0: unsigned
out_valid  out  1  out_data holds a valid byte
out_ready  in  1  consumer takes byte when out_valid && out_ready
out_data  out  8  ASCII byte ('-', '0'..'9', or 0x0A)
out_last  out  1  marks final byte of this conversion
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous: rstn=0 at a clock edge forces state IDLE, in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0. Digit count, sign flag and buffer are cleared.
- A reset taken mid-CONV or mid-EMIT abandons the conversion. No further bytes are emitted.
- States: IDLE -> CONV -> EMIT -> IDLE.
- IDLE:
  - in_ready=1. On in_valid && in_ready, latch the magnitude, clear cnt, and go to CONV.
  - Magnitude rule: if in_signed && in_data[31], neg=1 and mag = 32-bit two's-complement negate of in_data. 0x80000000 gives 0x80000000, which is correct as unsigned 2147483648. Otherwise neg=0 and mag = in_data.
- CONV, one digit per cycle:
  - q = div10(mag), computed as (mag * 0xCCCCCCCD) >> 35 with a full 64-bit product.
  - r = mag - mul10(q), where mul10(q) = (q<<3)+(q<<1) truncated to 32 bits. r is always in 0..9.
  - buf[cnt] <= 0x30 + r; cnt <= cnt+1; mag <= q.
  - If q == 0, go to EMIT. Input 0 therefore yields exactly one digit '0'.
  - cnt is 4 bits with a maximum of 10 digits; the buffer holds 10 entries of 8 bits.
  - in_ready=0 and out_valid=0 throughout CONV.
- EMIT, byte order:
  - '-' first if neg.
  - Then buf[cnt-1] down to buf[0].
  - Then 0x0A if APPEND_NL.
  - out_last=1 only with the final byte.
- Output handshake:
  - out_valid is registered. out_data and out_last are stable while out_valid && !out_ready.
  - The next byte is presented on the cycle after acceptance. Back-to-back acceptance sustains 1 byte/cycle.
  - out_valid must not drop without a handshake, except on reset.
- Leaving EMIT: on acceptance of the last byte, go to IDLE with out_valid=0 on the next cycle. in_ready rises that same cycle.
- No overlap: a new request is not accepted before the last byte of the previous one is accepted.
- Latency, from the accept edge T:
  - CONV occupies N cycles for an N-digit result.
  - The first out_valid is seen at cycle T+N+1.
  - With out_ready held at 1, the total bytes are N + neg + APPEND_NL, and busy drops at T+N+1+bytes.
- Maximum stream length: 10 digits for unsigned 4294967295; 11 bytes for signed -2147483648, plus 1 if APPEND_NL.
- in_signed=0 ignores bit 31 as a sign.
- Inputs while busy are ignored (in_ready=0). The requester holds in_valid/in_data until accepted.

Test Plan:
- in_data=0, in_signed=0, out_ready=1 -> single byte 0x30 with out_last=1, out_valid first at T+2, busy low at T+3.
- in_data=1234567890 unsigned, out_ready=1 -> bytes "1234567890" on 10 consecutive cycles from T+11, last on '0'.
- in_data=0xFFFFFFFF: with in_signed=1 -> "-1" (0x2D, 0x31); with in_signed=0 -> "4294967295".
- in_data=0x80000000, in_signed=1 -> "-2147483648", 11 bytes; with APPEND_NL=1, 12 bytes ending in 0x0A and out_last only on 0x0A.
- Backpressure on in_data=907: toggle out_ready randomly -> each byte held stable until accepted, order "907" with no duplicates or drops; in_ready stays 0 until the final accept.
- Reset mid-stream: rstn=0 for 1 cycle after 2 bytes of "123456" -> next cycle out_valid=0, in_ready=1. A following request of 42 yields exactly "42".
